// File: rtl/loop_nest_sequencer_if.sv
// Handshake/bus bundle for loop_nest_sequencer.
// The master drives run control and bounds; the slave (the sequencer) returns
// status, strobes, indices and statistics.
interface loop_nest_sequencer_if #(
  parameter int CW = 8
);
  logic          start;
  logic [CW-1:0] outer_n;
  logic [CW-1:0] inner_n;
  logic          hold;
  logic          abort;
  logic          busy;
  logic          done;
  logic          act1;
  logic          act2;
  logic [CW-1:0] x;
  logic [CW-1:0] y;
  logic [15:0]   act1_cnt;
  logic [15:0]   act2_cnt;

  modport master (
    output start, outer_n, inner_n, hold, abort,
    input  busy, done, act1, act2, x, y, act1_cnt, act2_cnt
  );

  modport slave (
    input  start, outer_n, inner_n, hold, abort,
    output busy, done, act1, act2, x, y, act1_cnt, act2_cnt
  );
endinterface

// File: rtl/loop_nest_sequencer.sv
// Two-level loop controller: issues act1 once per outer iteration followed by
// inner_n act2 strobes, then a one-cycle done pulse.
// Optional action statistics are enabled with the macro LOOP_SEQ_STATS_EN;
// without it act1_cnt/act2_cnt are constant zero.
module loop_nest_sequencer #(
  parameter int CW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  loop_nest_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_OUTER = 2'd1,
    S_INNER = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [CW-1:0] on_q, on_d;
  logic [CW-1:0] in_q, in_d;
  logic          accept;
  logic          act1, act2, busy, done;
  logic          x_last, y_last;

  assign x_last = (x_q == (on_q - ONE));
  assign y_last = (y_q == (in_q - ONE));

  // State, index and latched-bound registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      on_q    <= '0;
      in_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      on_q    <= on_d;
      in_q    <= in_d;
    end
  end

  // Next-state, index advance and output decode
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    on_d    = on_q;
    in_d    = in_q;
    accept  = 1'b0;
    busy    = (state_q != S_IDLE);
    // A pending done is dropped when abort arrives in the DONE cycle.
    done    = (state_q == S_DONE) && !bus.abort;
    act1    = (state_q == S_OUTER) && !bus.hold;
    act2    = (state_q == S_INNER) && !bus.hold;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          accept  = 1'b1;
          on_d    = bus.outer_n;
          in_d    = bus.inner_n;
          x_d     = '0;
          y_d     = '0;
          state_d = (bus.outer_n == '0) ? S_DONE : S_OUTER;
        end
      end
      S_OUTER: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (!bus.hold) begin
          if (in_q == '0) begin
            if (x_last) state_d = S_DONE;
            else        x_d     = x_q + ONE;
          end else begin
            y_d     = '0;
            state_d = S_INNER;
          end
        end
      end
      S_INNER: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (!bus.hold) begin
          if (!y_last) begin
            y_d = y_q + ONE;
          end else if (x_last) begin
            state_d = S_DONE;
          end else begin
            x_d     = x_q + ONE;
            y_d     = '0;
            state_d = S_OUTER;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.act1 = act1;
  assign bus.act2 = act2;
  assign bus.x    = x_q;
  assign bus.y    = y_q;

`ifdef LOOP_SEQ_STATS_EN
  logic [15:0] c1_q, c2_q;

  // Saturating strobe counters, cleared when a run is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c1_q <= '0;
      c2_q <= '0;
    end else if (accept) begin
      c1_q <= '0;
      c2_q <= '0;
    end else begin
      if (act1 && (c1_q != 16'hFFFF)) c1_q <= c1_q + 16'd1;
      if (act2 && (c2_q != 16'hFFFF)) c2_q <= c2_q + 16'd1;
    end
  end

  assign bus.act1_cnt = c1_q;
  assign bus.act2_cnt = c2_q;
`else
  assign bus.act1_cnt = '0;
  assign bus.act2_cnt = '0;
`endif

endmodule

// File: tb/tb_loop_nest_sequencer.sv
// Scoreboard bench for loop_nest_sequencer: expected strobe/done events are
// queued when a run is started and popped as the DUT produces them.
module tb_loop_nest_sequencer;

`ifdef LOOP_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    int k;   // 1 = act1, 2 = act2, 3 = done
    int x;
    int y;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  loop_nest_sequencer_if #(.CW(8)) bus ();

  loop_nest_sequencer #(.CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  int   t0     = 0;
  ev_t  q[$];

  // monitor-owned statistics
  int   n_a1 = 0, n_a2 = 0, n_done = 0, busy_cnt = 0;
  int   done_cyc = -1, busy_rise = -1;
  logic prev_busy = 1'b0;

  // run snapshots (owned by the stimulus process)
  int   a1_0, a2_0, d0, b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int cnt_exp(input int v);
    return STATS ? v : 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    int  rel;
    int  k;
    ev_t e;
    if (rst_n) begin
      rel = cyc - t0 + 1;
      if (bus.busy) busy_cnt++;
      if (bus.busy && !prev_busy) busy_rise = rel;
      prev_busy = bus.busy;
      if (bus.hold && (bus.act1 || bus.act2)) check("strobe_in_hold", 1, 0);
      if (bus.act1 || bus.act2 || bus.done) begin
        k = bus.act1 ? 1 : (bus.act2 ? 2 : 3);
        if (q.size() == 0) begin
          check("unexpected_event", k, 0);
        end else begin
          e = q.pop_front();
          check("ev_kind", k, e.k);
          check("ev_x", int'(bus.x), e.x);
          check("ev_y", int'(bus.y), e.y);
        end
        if (bus.act1) n_a1++;
        if (bus.act2) n_a2++;
        if (bus.done) begin
          n_done++;
          done_cyc = rel;
        end
      end
    end else begin
      prev_busy = 1'b0;
    end
  end

  task automatic push_run(input int o, input int i);
    for (int xx = 0; xx < o; xx++) begin
      q.push_back('{k: 1, x: xx, y: 0});
      for (int yy = 0; yy < i; yy++) q.push_back('{k: 2, x: xx, y: yy});
    end
    if (o == 0) q.push_back('{k: 3, x: 0, y: 0});
    else        q.push_back('{k: 3, x: o - 1, y: (i == 0) ? 0 : i - 1});
  endtask

  // Drives a one-cycle start; returns #1 into cycle 1 of the run.
  task automatic run_start(input int o, input int i, input bit now);
    logic [7:0] ob, ib;
    if (!now) begin
      @(posedge clk); #1;
    end
    ob = o[7:0];
    ib = i[7:0];
    bus.start   = 1'b1;
    bus.outer_n = ob;
    bus.inner_n = ib;
    push_run(o, i);
    t0   = cyc + 1;
    a1_0 = n_a1;
    a2_0 = n_a2;
    d0   = n_done;
    b0   = busy_cnt;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    bus.outer_n = 8'hFF;
    bus.inner_n = 8'hFF;
  endtask

  // Waits (bounded) for the done pulse; returns #1 into the cycle after DONE.
  task automatic wait_done(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (n_done != d0) break;
      @(posedge clk);
    end
    check("done_seen", n_done - d0, 1);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.outer_n = '0;
    bus.inner_n = '0;
    bus.hold    = 1'b0;
    bus.abort   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_act1", int'(bus.act1), 0);
    check("rst_act2", int'(bus.act2), 0);
    check("rst_x",    int'(bus.x), 0);
    check("rst_y",    int'(bus.y), 0);
    check("rst_c1",   int'(bus.act1_cnt), 0);
    check("rst_c2",   int'(bus.act2_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 10x10 run with a foreign start pulse mid-run
    run_start(10, 10, 1'b0);
    repeat (29) @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.outer_n = 8'd3;
    bus.inner_n = 8'd2;
    @(posedge clk); #1;
    bus.start   = 1'b0;
    wait_done(200);
    check("t1_done_cyc", done_cyc, 111);
    check("t1_act1", n_a1 - a1_0, 10);
    check("t1_act2", n_a2 - a2_0, 100);
    check("t1_busy_cycles", busy_cnt - b0, 111);
    check("t1_busy_rise", busy_rise, 1);
    check("t1_c1", int'(bus.act1_cnt), cnt_exp(10));
    check("t1_c2", int'(bus.act2_cnt), cnt_exp(100));
    check("t1_q_empty", q.size(), 0);

    // back-to-back 2x4 run with 5 hold cycles from the 2nd act2
    run_start(2, 4, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.hold = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.hold = 1'b0;
    wait_done(100);
    check("hold_done_cyc", done_cyc, 16);
    check("hold_act1", n_a1 - a1_0, 2);
    check("hold_act2", n_a2 - a2_0, 8);
    check("hold_c1", int'(bus.act1_cnt), cnt_exp(2));
    check("hold_c2", int'(bus.act2_cnt), cnt_exp(8));

    // abort at cycle 20 of a 10x10 run
    run_start(10, 10, 1'b0);
    repeat (19) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_act1", n_a1 - a1_0, 2);
    check("abort_act2", n_a2 - a2_0, 18);
    q.delete();
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_done", n_done - d0, 0);
    check("abort_c1", int'(bus.act1_cnt), cnt_exp(2));
    check("abort_c2", int'(bus.act2_cnt), cnt_exp(18));

    // start together with abort in IDLE must not launch a run
    bus.start   = 1'b1;
    bus.abort   = 1'b1;
    bus.outer_n = 8'd4;
    bus.inner_n = 8'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("startabort_busy", int'(bus.busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check("startabort_busy_later", int'(bus.busy), 0);

    // full run after the abort
    run_start(3, 2, 1'b0);
    wait_done(100);
    check("post_abort_done_cyc", done_cyc, 10);
    check("post_abort_act2", n_a2 - a2_0, 6);

    // asynchronous reset at cycle 50 of a 10x10 run
    run_start(10, 10, 1'b0);
    repeat (49) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_busy", int'(bus.busy), 0);
    check("arst_act",  int'(bus.act1 | bus.act2), 0);
    check("arst_done", int'(bus.done), 0);
    check("arst_x",    int'(bus.x), 0);
    check("arst_y",    int'(bus.y), 0);
    check("arst_c1",   int'(bus.act1_cnt), 0);
    check("arst_c2",   int'(bus.act2_cnt), 0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // inner_n = 0: act1 only
    run_start(3, 0, 1'b0);
    wait_done(50);
    check("i0_done_cyc", done_cyc, 4);
    check("i0_act1", n_a1 - a1_0, 3);
    check("i0_act2", n_a2 - a2_0, 0);
    check("i0_c1", int'(bus.act1_cnt), cnt_exp(3));

    // outer_n = 0: straight to DONE
    run_start(0, 5, 1'b0);
    wait_done(20);
    check("o0_done_cyc", done_cyc, 1);
    check("o0_busy_cycles", busy_cnt - b0, 1);
    check("o0_busy_rise", busy_rise, 1);
    check("o0_strobes", (n_a1 - a1_0) + (n_a2 - a2_0), 0);
    check("o0_c2", int'(bus.act2_cnt), 0);
    check("final_q_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
